// File: rtl/part_dpram_be_pkg.sv
// Shared constants, clear-sequencer state type and the byte-lane merge helper
// for the byte-enabled true dual-port RAM.
package part_dpram_be_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_t;

    function automatic logic [7:0] lane_pick(input logic [7:0] cur,
                                             input logic [7:0] wdata,
                                             input logic       en);
        return en ? wdata : cur;
    endfunction

endpackage

// File: rtl/part_dpram_clrseq.sv
// Post-reset clear sequencer: walks every word once, writing CLR_VAL, while
// holding busy so that both RAM ports are locked out.
//
// state     | meaning
// CLR_IDLE  | normal operation, ports own the array
// CLR_CLEAR | writing CLR_VAL to word cnt, port requests ignored
module part_dpram_clrseq
    import part_dpram_be_pkg::*;
#(
    parameter int              AW      = 5,
    parameter int              DW      = 32,
    parameter int              CLR_EN  = 1,
    parameter logic [DW-1:0]   CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr,
    output logic [DW-1:0] clr_data
);

    localparam clr_state_t RST_STATE = (CLR_EN != 0) ? CLR_CLEAR : CLR_IDLE;

    clr_state_t    state, state_nx;
    logic [AW-1:0] cnt, cnt_nx;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RST_STATE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        case (state)
            CLR_CLEAR: begin
                clr_we = reset_n;
                cnt_nx = cnt + AW'(1);
                if (cnt == {AW{1'b1}}) state_nx = CLR_IDLE;
            end
            default: ;
        endcase
    end

    assign busy     = (state == CLR_CLEAR);
    assign clr_addr = cnt;
    assign clr_data = CLR_VAL;

endmodule

// File: rtl/part_dpram_be.sv
// Single-clock true dual-port RAM with byte enables, port-A-wins same-address
// arbitration, selectable read-during-write result and optional output register.
module part_dpram_be
    import part_dpram_be_pkg::*;
#(
    parameter int            AW       = 5,
    parameter int            DW       = 32,
    parameter int            RDW_MODE = RDW_OLD,
    parameter int            OUT_REG  = 0,
    parameter int            CLR_EN   = 1,
    parameter logic [DW-1:0] CLR_VAL  = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_din,
    input  logic [DW/8-1:0] a_be,
    input  logic            a_wren,
    input  logic            a_rden,
    output logic [DW-1:0]   a_q,
    input  logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_din,
    input  logic [DW/8-1:0] b_be,
    input  logic            b_wren,
    input  logic            b_rden,
    output logic [DW-1:0]   b_q,
    output logic            busy,
    output logic            collision
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    if ((DW % 8) != 0 || DW == 0) begin : g_dw_check
        $error("part_dpram_be: DW must be a non-zero multiple of 8");
    end

    logic [DW-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic [DW-1:0] clr_data;

    part_dpram_clrseq #(
        .AW(AW), .DW(DW), .CLR_EN(CLR_EN), .CLR_VAL(CLR_VAL)
    ) u_clrseq (
        .clk(clk), .reset_n(reset_n), .busy(busy),
        .clr_we(clr_we), .clr_addr(clr_addr), .clr_data(clr_data)
    );

    logic          ports_on, same_addr, a_rd_go, b_rd_go;
    logic [NB-1:0] a_lane, b_lane;
    logic [DW-1:0] a_new, b_new, a_rd, b_rd, a_r, b_r;

    assign ports_on  = reset_n && !busy;
    assign same_addr = (a_addr == b_addr);
    assign a_rd_go   = ports_on && a_rden;
    assign b_rd_go   = ports_on && b_rden;

    // Port A owns any lane it enables; B keeps only the leftover lanes on a shared word.
    assign a_lane = (ports_on && a_wren) ? a_be : '0;
    assign b_lane = (ports_on && b_wren) ? (b_be & ~(same_addr ? a_lane : '0)) : '0;

    always_comb begin
        a_new = mem[a_addr];
        b_new = mem[b_addr];
        for (int i = 0; i < NB; i++) begin
            a_new[8*i +: 8] = lane_pick(a_new[8*i +: 8], a_din[8*i +: 8], a_lane[i]);
            a_new[8*i +: 8] = lane_pick(a_new[8*i +: 8], b_din[8*i +: 8], b_lane[i] && same_addr);
            b_new[8*i +: 8] = lane_pick(b_new[8*i +: 8], b_din[8*i +: 8], b_lane[i]);
            b_new[8*i +: 8] = lane_pick(b_new[8*i +: 8], a_din[8*i +: 8], a_lane[i] && same_addr);
        end
    end

    assign a_rd = (RDW_MODE == RDW_NEW) ? a_new : mem[a_addr];
    assign b_rd = (RDW_MODE == RDW_NEW) ? b_new : mem[b_addr];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= clr_data;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (a_lane[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
                if (b_lane[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_r       <= '0;
            b_r       <= '0;
            collision <= 1'b0;
        end else begin
            if (a_rd_go) a_r <= a_rd;
            if (b_rd_go) b_r <= b_rd;
            collision <= ports_on && a_wren && b_wren && same_addr && ((a_be & b_be) != '0);
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic          a_v, b_v;
        logic [DW-1:0] a_o, b_o;

        // The second stage only moves when the first stage loaded on the previous edge.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                a_v <= 1'b0;
                b_v <= 1'b0;
                a_o <= '0;
                b_o <= '0;
            end else begin
                a_v <= a_rd_go;
                b_v <= b_rd_go;
                if (a_v) a_o <= a_r;
                if (b_v) b_o <= b_r;
            end
        end

        assign a_q = a_o;
        assign b_q = b_o;
    end else begin : g_noreg
        assign a_q = a_r;
        assign b_q = b_r;
    end

endmodule

// File: tb/tb_part_dpram_be.sv
// Bench for part_dpram_be: two instances (old-data/latency-1 and new-data/latency-2)
// share stimulus and are checked every cycle against a word-level array model.
module tb_part_dpram_be;

    localparam logic [31:0] CLR1 = 32'hA5A5_0F0F;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_din, b_din;
    logic [3:0]  a_be, b_be;
    logic        a_wren, a_rden, b_wren, b_rden;
    logic [31:0] a_q0, b_q0, a_q1, b_q1;
    logic        busy0, busy1, col0, col1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    part_dpram_be #(.AW(5), .DW(32), .RDW_MODE(0), .OUT_REG(0), .CLR_EN(1), .CLR_VAL(32'h0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .a_addr(a_addr), .a_din(a_din), .a_be(a_be), .a_wren(a_wren), .a_rden(a_rden), .a_q(a_q0),
        .b_addr(b_addr), .b_din(b_din), .b_be(b_be), .b_wren(b_wren), .b_rden(b_rden), .b_q(b_q0),
        .busy(busy0), .collision(col0)
    );

    part_dpram_be #(.AW(5), .DW(32), .RDW_MODE(1), .OUT_REG(1), .CLR_EN(1), .CLR_VAL(CLR1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .a_addr(a_addr), .a_din(a_din), .a_be(a_be), .a_wren(a_wren), .a_rden(a_rden), .a_q(a_q1),
        .b_addr(b_addr), .b_din(b_din), .b_be(b_be), .b_wren(b_wren), .b_rden(b_rden), .b_q(b_q1),
        .busy(busy1), .collision(col1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays, a clear countdown, and read results with latency.
    logic [31:0] m0 [32];
    logic [31:0] m1 [32];
    int          busy_left = 0;
    bit          model_on  = 1'b0;
    bit          e_col, v1a, v1b;
    logic [31:0] e0a, e0b, s1a, s1b, e1a, e1b;
    logic [31:0] wa0, wb0, wa1, wb1;

    function automatic logic [31:0] post(input logic [31:0] old, input logic [4:0] ad);
        logic [31:0] w = old;
        for (int i = 0; i < 4; i++) begin
            if (a_wren && a_be[i] && a_addr == ad)      w[8*i +: 8] = a_din[8*i +: 8];
            else if (b_wren && b_be[i] && b_addr == ad) w[8*i +: 8] = b_din[8*i +: 8];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            model_on  = 1'b1;
            busy_left = 32;
            e_col = 0; v1a = 0; v1b = 0;
            e0a = 0; e0b = 0; s1a = 0; s1b = 0; e1a = 0; e1b = 0;
        end else if (busy_left > 0) begin
            busy_left--;
            e_col = 0; v1a = 0; v1b = 0;
            if (busy_left == 0)
                for (int i = 0; i < 32; i++) begin
                    m0[i] = 32'h0;
                    m1[i] = CLR1;
                end
        end else begin
            if (v1a) e1a = s1a;
            if (v1b) e1b = s1b;
            v1a = a_rden;
            v1b = b_rden;
            if (a_rden) begin e0a = m0[a_addr]; s1a = post(m1[a_addr], a_addr); end
            if (b_rden) begin e0b = m0[b_addr]; s1b = post(m1[b_addr], b_addr); end
            e_col = a_wren && b_wren && (a_addr == b_addr) && ((a_be & b_be) != 4'h0);
            wa0 = post(m0[a_addr], a_addr);
            wb0 = post(m0[b_addr], b_addr);
            wa1 = post(m1[a_addr], a_addr);
            wb1 = post(m1[b_addr], b_addr);
            m0[a_addr] = wa0; m0[b_addr] = wb0;
            m1[a_addr] = wa1; m1[b_addr] = wb1;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("a_q0", a_q0, e0a);
            chk("b_q0", b_q0, e0b);
            chk("a_q1", a_q1, e1a);
            chk("b_q1", b_q1, e1b);
            chk("busy0", 32'(busy0), 32'(busy_left > 0));
            chk("busy1", 32'(busy1), 32'(busy_left > 0));
            chk("collision0", 32'(col0), 32'(e_col));
            chk("collision1", 32'(col1), 32'(e_col));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_a(input logic w, input logic r, input logic [4:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        a_wren = w; a_rden = r; a_addr = ad; a_din = d; a_be = be;
    endtask

    task automatic set_b(input logic w, input logic r, input logic [4:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        b_wren = w; b_rden = r; b_addr = ad; b_din = d; b_be = be;
    endtask

    task automatic idle_all();
        set_a(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        set_b(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
    endtask

    task automatic busy_len(output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (!busy0) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        idle_all();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;

        // Writes during the clear are dropped.
        set_a(1'b1, 1'b1, 5'h3, 32'hDEAD_BEEF, 4'hF);
        tick(4);
        chk("busy_during_clear", 32'(busy0), 32'h1);
        idle_all();
        busy_len(n);
        chk("busy_length", 32'(n + 4), 32'd32);
        set_a(1'b0, 1'b1, 5'h3, 32'h0, 4'h0);
        tick(1);
        chk("read3_cleared0", a_q0, 32'h0);
        idle_all();
        tick(1);
        chk("read3_cleared1", a_q1, CLR1);

        // Partial byte write merges into the existing word.
        set_a(1'b1, 1'b0, 5'h5, 32'h1122_3344, 4'hF);
        tick(1);
        set_a(1'b1, 1'b0, 5'h5, 32'hAABB_CCDD, 4'b0101);
        tick(1);
        set_a(1'b0, 1'b1, 5'h5, 32'h0, 4'h0);
        tick(1);
        chk("merge0", a_q0, 32'h11BB_33DD);
        idle_all();
        tick(1);
        chk("merge1", a_q1, 32'h11BB_33DD);

        // Same-address dual write with overlapping lanes.
        set_a(1'b1, 1'b0, 5'h7, 32'hFFFF_FFFF, 4'b0011);
        set_b(1'b1, 1'b0, 5'h7, 32'h0, 4'b0110);
        tick(1);
        chk("collision_pulse", 32'(col0), 32'h1);
        idle_all();
        tick(1);
        chk("collision_drop", 32'(col0), 32'h0);
        set_b(1'b0, 1'b1, 5'h7, 32'h0, 4'h0);
        tick(1);
        chk("arb0", b_q0, 32'h0000_FFFF);
        idle_all();
        tick(1);
        chk("arb1", b_q1, 32'hA500_FFFF);

        // Read-during-write from the other port.
        set_a(1'b1, 1'b0, 5'h9, 32'h1, 4'hF);
        tick(1);
        set_a(1'b1, 1'b0, 5'h9, 32'h2, 4'hF);
        set_b(1'b0, 1'b1, 5'h9, 32'h0, 4'h0);
        tick(1);
        chk("rdw_old", b_q0, 32'h1);
        idle_all();
        tick(1);
        chk("rdw_new", b_q1, 32'h2);

        // Output register latency and hold.
        set_a(1'b1, 1'b0, 5'hC, 32'h600D_F00D, 4'hF);
        tick(1);
        set_a(1'b0, 1'b1, 5'hC, 32'h0, 4'h0);
        tick(1);
        chk("lat1", a_q0, 32'h600D_F00D);
        chk("lat2_not_yet", a_q1, 32'h11BB_33DD);
        idle_all();
        set_b(1'b1, 1'b0, 5'hC, 32'h1234_5678, 4'hF);
        tick(1);
        chk("lat2", a_q1, 32'h600D_F00D);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("hold", a_q1, 32'h600D_F00D);
        end
        idle_all();

        // Reset in the middle of a clear restarts it from word 0.
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        tick(17);
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        busy_len(n);
        chk("restart_busy_length", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) begin
            set_a(1'b0, 1'b1, 5'(i), 32'h0, 4'h0);
            tick(1);
            chk("sweep0", a_q0, 32'h0);
            if (i > 0) chk("sweep1", a_q1, CLR1);
        end
        idle_all();
        tick(1);

        // Random traffic, biased towards few addresses to provoke collisions.
        for (int k = 0; k < 2000; k++) begin
            reset_n = ($urandom_range(0, 399) != 0);
            set_a(1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  $urandom, 4'($urandom));
            set_b(1'($urandom), 1'($urandom),
                  ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom),
                  $urandom, 4'($urandom));
            tick(1);
        end
        reset_n = 1'b1;
        idle_all();
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
